// File: rtl/key_event_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : key_event_if
// Purpose  : Bundles the debounced key level and the classified key events
//            exchanged between a key source and key_event_detector.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface key_event_if;
    logic signal_i;        // debounced key level, synchronous to clk
    logic pressed_o;       // registered key-active level
    logic click_o;         // single click confirmed
    logic double_click_o;  // second press inside the double-click window
    logic long_press_o;    // key held for the long-press time
    logic repeat_o;        // auto-repeat tick while held after long press
    logic busy_o;          // classifier not idle

    // Key source / event consumer side
    modport master (
        output signal_i,
        input  pressed_o,
        input  click_o,
        input  double_click_o,
        input  long_press_o,
        input  repeat_o,
        input  busy_o
    );

    // Detector side
    modport slave (
        input  signal_i,
        output pressed_o,
        output click_o,
        output double_click_o,
        output long_press_o,
        output repeat_o,
        output busy_o
    );
endinterface
`default_nettype wire

// File: rtl/key_event_detector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : key_event_detector
// Purpose  : Turns a clean key level into one-cycle click / double-click /
//            long-press / auto-repeat pulses plus a registered pressed level.
//            All outputs are registered; at most one event pulse per cycle.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module key_event_detector #(
    parameter int unsigned ACTIVE_LEVEL = 1,
    parameter int unsigned LONG_TIME    = 50_000_000,
    parameter int unsigned DOUBLE_GAP   = 12_500_000,
    parameter int unsigned REPEAT_TIME  = 10_000_000,
    parameter int unsigned CNT_W        = 26
) (
    input  wire logic     clk,
    input  wire logic     rst,
    key_event_if.slave    bus
);

    // Terminal counter values: each timed state leaves (or re-arms) when the
    // counter reaches its last value, so the counter never wraps.
    localparam logic             c_ACTIVE      = 1'(ACTIVE_LEVEL);
    localparam logic [CNT_W-1:0] c_LONG_LAST   = CNT_W'(LONG_TIME - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST    = CNT_W'(DOUBLE_GAP - 1);
    localparam logic [CNT_W-1:0] c_REPEAT_LAST = CNT_W'(REPEAT_TIME - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,  // waiting for a press
        S_PRESS1 = 3'd1,  // first press, timing towards long press
        S_GAP    = 3'd2,  // released, waiting for a possible second press
        S_PRESS2 = 3'd3,  // second press of a double click, wait release
        S_HOLD   = 3'd4   // long press reached, generating repeats
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_dly_q;
    logic             click_q, click_d;
    logic             double_click_q, double_click_d;
    logic             long_press_q, long_press_d;
    logic             repeat_q, repeat_d;
    logic             busy_q, busy_d;

    logic             w_p;
    logic             w_press_edge;

    // Key-active level and its rising edge against the previous sample.
    assign w_p          = (bus.signal_i == c_ACTIVE);
    assign w_press_edge = w_p & ~key_dly_q;

    // Next-state, counter and event-pulse decode.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        click_d        = 1'b0;
        double_click_d = 1'b0;
        long_press_d   = 1'b0;
        repeat_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (w_press_edge) begin
                    state_d = S_PRESS1;
                end
            end

            S_PRESS1: begin
                // Release takes priority over reaching the long-press time.
                if (!w_p) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == c_LONG_LAST) begin
                    long_press_d = 1'b1;
                    state_d      = S_HOLD;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_GAP: begin
                // A press on the timeout edge still counts as a double click.
                if (w_p) begin
                    double_click_d = 1'b1;
                    state_d        = S_PRESS2;
                    cnt_d          = '0;
                end else if (cnt_q == c_GAP_LAST) begin
                    click_d = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_PRESS2: begin
                // A double-click press never escalates to long press.
                cnt_d = '0;
                if (!w_p) begin
                    state_d = S_IDLE;
                end
            end

            S_HOLD: begin
                if (!w_p) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == c_REPEAT_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, counter, key sample and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            key_dly_q      <= 1'b0;
            click_q        <= 1'b0;
            double_click_q <= 1'b0;
            long_press_q   <= 1'b0;
            repeat_q       <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            key_dly_q      <= w_p;
            click_q        <= click_d;
            double_click_q <= double_click_d;
            long_press_q   <= long_press_d;
            repeat_q       <= repeat_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.pressed_o      = key_dly_q;
    assign bus.click_o        = click_q;
    assign bus.double_click_o = double_click_q;
    assign bus.long_press_o   = long_press_q;
    assign bus.repeat_o       = repeat_q;
    assign bus.busy_o         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_key_event_detector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_key_event_detector
// Purpose  : Directed, table-driven checks of key_event_detector with short
//            timing parameters; one instance active-high, one active-low.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_key_event_detector;

    logic clk;
    logic rst;

    key_event_if if_hi ();
    key_event_if if_lo ();

    key_event_detector #(
        .ACTIVE_LEVEL (1),
        .LONG_TIME    (8),
        .DOUBLE_GAP   (5),
        .REPEAT_TIME  (3),
        .CNT_W        (4)
    ) u_dut_hi (
        .clk (clk),
        .rst (rst),
        .bus (if_hi)
    );

    key_event_detector #(
        .ACTIVE_LEVEL (0),
        .LONG_TIME    (8),
        .DOUBLE_GAP   (5),
        .REPEAT_TIME  (3),
        .CNT_W        (4)
    ) u_dut_lo (
        .clk (clk),
        .rst (rst),
        .bus (if_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: {pressed, click, double_click, long_press, repeat, busy}
    localparam logic [5:0] E_IDLE  = 6'b000000;
    localparam logic [5:0] E_HELD  = 6'b100001;
    localparam logic [5:0] E_GAP   = 6'b000001;
    localparam logic [5:0] E_CLICK = 6'b010000;
    localparam logic [5:0] E_DBL   = 6'b101001;
    localparam logic [5:0] E_LONG  = 6'b100101;
    localparam logic [5:0] E_REP   = 6'b100011;

    typedef struct {
        int         tid;   // test number
        logic       sel;   // 0: active-high instance, 1: active-low instance
        logic       r;     // rst for this edge
        logic       sig;   // raw signal level for this edge
        logic [5:0] exp;   // outputs expected just after this edge
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   step_no  = 0;

    task automatic add(input int tid, input logic sel, input logic r,
                       input logic sig, input logic [5:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            tbl.push_back('{tid, sel, r, sig, exp});
        end
    endtask

    // Drive one edge, then compare the selected instance's outputs.
    task automatic step(input int tid, input logic sel, input logic r,
                        input logic sig, input logic [5:0] exp);
        logic [5:0] got;
        rst = r;
        if (sel) begin
            if_lo.signal_i = sig;
            if_hi.signal_i = 1'b0;
        end else begin
            if_hi.signal_i = sig;
            if_lo.signal_i = 1'b1;
        end
        @(posedge clk);
        #1;
        if (sel)
            got = {if_lo.pressed_o, if_lo.click_o, if_lo.double_click_o,
                   if_lo.long_press_o, if_lo.repeat_o, if_lo.busy_o};
        else
            got = {if_hi.pressed_o, if_hi.click_o, if_hi.double_click_o,
                   if_hi.long_press_o, if_hi.repeat_o, if_hi.busy_o};
        n_checks++;
        step_no++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL test%0d step %0d outputs{prs,clk,dbl,lng,rep,bsy}: got %b expected %b",
                     tid, step_no, got, exp);
        end
    endtask

    initial begin
        rst            = 1'b1;
        if_hi.signal_i = 1'b0;
        if_lo.signal_i = 1'b1;

        // Reset state
        add(0, 0, 1, 0, E_IDLE, 2);
        // 1: single click, held 3 samples
        add(1, 0, 0, 1, E_HELD, 3);
        add(1, 0, 0, 0, E_GAP, 5);
        add(1, 0, 0, 0, E_CLICK, 1);
        add(1, 0, 0, 0, E_IDLE, 3);
        // 2: double click, high 2 / low 3 / high 2 / low
        add(2, 0, 0, 1, E_HELD, 2);
        add(2, 0, 0, 0, E_GAP, 3);
        add(2, 0, 0, 1, E_DBL, 1);
        add(2, 0, 0, 1, E_HELD, 1);
        add(2, 0, 0, 0, E_IDLE, 7);
        // 2 variant: second press on the timeout edge R0+5
        add(3, 0, 0, 1, E_HELD, 2);
        add(3, 0, 0, 0, E_GAP, 5);
        add(3, 0, 0, 1, E_DBL, 1);
        add(3, 0, 0, 0, E_IDLE, 3);
        // 4a: release on E0+8 beats long press
        add(4, 0, 0, 1, E_HELD, 8);
        add(4, 0, 0, 0, E_GAP, 5);
        add(4, 0, 0, 0, E_CLICK, 1);
        add(4, 0, 0, 0, E_IDLE, 2);
        // 4b: held 9 samples -> long press, release without click
        add(5, 0, 0, 1, E_HELD, 8);
        add(5, 0, 0, 1, E_LONG, 1);
        add(5, 0, 0, 0, E_IDLE, 7);
        // 5a: reset in GAP at cnt=2 cancels the click
        add(6, 0, 0, 1, E_HELD, 2);
        add(6, 0, 0, 0, E_GAP, 3);
        add(6, 0, 1, 0, E_IDLE, 1);
        add(6, 0, 0, 0, E_IDLE, 8);
        // 5b: key held through reset -> fresh press afterwards
        add(7, 0, 0, 1, E_HELD, 2);
        add(7, 0, 1, 1, E_IDLE, 1);
        add(7, 0, 0, 1, E_HELD, 8);
        add(7, 0, 0, 1, E_LONG, 1);
        add(7, 0, 0, 0, E_IDLE, 2);
        // 6: active-low instance, signal low for 3 samples
        add(8, 1, 0, 0, E_HELD, 3);
        add(8, 1, 0, 1, E_GAP, 5);
        add(8, 1, 0, 1, E_CLICK, 1);
        add(8, 1, 0, 1, E_IDLE, 3);

        foreach (tbl[i]) begin
            step(tbl[i].tid, tbl[i].sel, tbl[i].r, tbl[i].sig, tbl[i].exp);
        end

        // 3: long press with repeat; held on edges E0..E0+20
        for (int k = 0; k <= 20; k++) begin
            logic [5:0] e;
            e = E_HELD;
            if (k == 8)
                e = E_LONG;
            else if (k > 8 && ((k - 8) % 3) == 0)
                e = E_REP;
            step(9, 0, 0, 1, e);
        end
        step(9, 0, 0, 0, E_IDLE);
        for (int k = 0; k < 6; k++) step(9, 0, 0, 0, E_IDLE);

        // Long hold on the second press of a double click: no long/repeat
        step(10, 0, 0, 1, E_HELD);
        step(10, 0, 0, 1, E_HELD);
        step(10, 0, 0, 0, E_GAP);
        step(10, 0, 0, 1, E_DBL);
        for (int k = 0; k < 15; k++) step(10, 0, 0, 1, E_HELD);
        for (int k = 0; k < 3; k++)  step(10, 0, 0, 0, E_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
